serial_det_sched: RTL and testbench

Round-robin scheduler that shares one serial sequence-detector FSM among NREQ requesters. It accepts a WIDTH-bit word from the granted requester and clears the detector. It then shifts the word into the detector MSB-first, one bit per clock, samples the detector's Mealy output after every bit, and reports the number of detector hits and the final output bit. It sits between the requesting blocks and the single detector instance, and is the only driver of the detector's input and reset.

---
 rtl/serial_det_sched.sv | 170 +++++++++++++++++
 tb/tb_serial_det_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_det_sched.sv
// rtl/serial_det_sched.sv - round-robin scheduler sharing one serial sequence detector
// Captures a word from the granted requester, clears the detector, shifts the word MSB-first and counts hits.
module serial_det_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ),
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  det_x,
  output logic                  det_rst_n,
  input  logic                  det_y,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CW-1:0]         hit_count,
  output logic                  last_y
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   cand;
  logic             found;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sel_word;
  logic [SW-1:0]    bit_s;
  logic [SW-1:0]    bit_nx;
  logic [CW-1:0]    cnt;

  logic [NREQ-1:0]  gnt_d;
  logic             det_x_d;
  logic             det_rst_n_d;
  logic             busy_d;
  logic             done_d;
  logic [IDW-1:0]   done_id_d;
  logic [CW-1:0]    hit_count_d;
  logic             last_y_d;

  // First set request at or after ptr, searching upward with wrap.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        sel_word = data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (found) state_nx = ST_CLR;
      ST_CLR:   state_nx = ST_SHIFT;
      ST_SHIFT: if (bit_s == SW'(WIDTH - 1)) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign bit_nx = (state == ST_SHIFT) ? bit_s + 1'b1 : '0;

  // Outputs are computed from the upcoming state so every port comes straight from a flop.
  always_comb begin
    gnt_d       = '0;
    det_x_d     = 1'b0;
    det_rst_n_d = 1'b1;
    busy_d      = (state_nx != ST_IDLE);
    done_d      = (state_nx == ST_DONE);
    done_id_d   = done_id;
    hit_count_d = hit_count;
    last_y_d    = last_y;
    if (state_nx == ST_CLR) begin
      gnt_d[sel]  = 1'b1;
      det_rst_n_d = 1'b0;
    end
    if (state_nx == ST_SHIFT) begin
      det_x_d = word[SW'(WIDTH - 1) - bit_nx];
    end
    if (state_nx == ST_DONE) begin
      done_id_d   = idx;
      hit_count_d = cnt + CW'(det_y);
      last_y_d    = det_y;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      idx   <= '0;
      word  <= '0;
      bit_s <= '0;
      cnt   <= '0;
    end else begin
      if (state == ST_IDLE && found) begin
        word <= sel_word;
        idx  <= sel;
        ptr  <= (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
      end
      bit_s <= bit_nx;
      // The sample at the end of shift bit 0 precedes any detector response and is skipped.
      if (state == ST_CLR) begin
        cnt <= '0;
      end else if (state == ST_SHIFT && bit_s != '0) begin
        cnt <= cnt + CW'(det_y);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      det_x     <= 1'b0;
      det_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
      last_y    <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      det_x     <= det_x_d;
      det_rst_n <= det_rst_n_d;
      busy      <= busy_d;
      done      <= done_d;
      done_id   <= done_id_d;
      hit_count <= hit_count_d;
      last_y    <= last_y_d;
    end
  end

endmodule

// File: tb/tb_serial_det_sched.sv
// tb/tb_serial_det_sched.sv - self-checking bench for serial_det_sched
// Drives requesters and a scripted det_y; a round-robin model predicts grants and hit results.
module tb_serial_det_sched;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] data  = '0;
  logic           det_y = 1'b0;
  logic [N-1:0]   gnt;
  logic           det_x;
  logic           det_rst_n;
  logic           busy;
  logic           done;
  logic [IDW-1:0] done_id;
  logic [CW-1:0]  hit_count;
  logic           last_y;

  serial_det_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .det_x     (det_x),
    .det_rst_n (det_rst_n),
    .det_y     (det_y),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count),
    .last_y    (last_y)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int           n_assert  = 0;
  int           n_fail    = 0;
  logic [W-1:0] words [N];
  logic [W-1:0] ypats [N];
  logic [N-1:0] pend      = '0;
  int           mptr      = 0;
  int           prev_id   = 0;
  int           prev_hit  = 0;
  int           prev_last = 0;
  int           last_gcyc = 0;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_of(input logic [W-1:0] v, input int i);
    logic [2:0] k;
    k = 3'(i);
    return v[k];
  endfunction

  task automatic set_word(input int id, input logic [W-1:0] w, input logic [W-1:0] y);
    words[id] = w;
    ypats[id] = y;
    data = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_hold_id"}, 32'(done_id), prev_id);
    chk({tag, "_hold_hit"}, 32'(hit_count), prev_hit);
    chk({tag, "_hold_last"}, 32'(last_y), prev_last);
  endtask

  // Waits for the next grant, checks it against the model and follows the word through DONE.
  task automatic serve(input int gap_exp, input logic [N-1:0] raise_mid);
    int           exp_id;
    int           wait_n;
    logic [W-1:0] w;
    logic [W-1:0] yp;
    logic [N-1:0] oh;
    exp_id = -1;
    for (int k = 0; k < N; k++) begin
      if (exp_id < 0 && ((pend >> ((mptr + k) % N)) & 1) != 0) exp_id = (mptr + k) % N;
    end
    if (exp_id < 0) begin
      chk("serve_pending", 0, 1);
      return;
    end
    oh = N'(1) << exp_id;
    wait_n = 0;
    while (gnt === '0 && wait_n < 40) begin
      @(negedge clock);
      wait_n++;
    end
    chk("gnt_onehot", 32'(gnt), 32'(oh));
    pend = pend & ~oh;
    req  = pend;
    if (gnt !== oh) return;
    chk("clr_busy", 32'(busy), 1);
    chk("clr_rstn", 32'(det_rst_n), 0);
    chk("clr_done", 32'(done), 0);
    chk_hold("clr");
    if (gap_exp > 0) chk("gnt_gap", cyc - last_gcyc, gap_exp);
    last_gcyc = cyc;
    mptr  = (exp_id + 1) % N;
    det_y = 1'($urandom);
    w  = words[exp_id];
    yp = ypats[exp_id];
    for (int c = 2; c <= W + 3; c++) begin
      @(negedge clock);
      if (c == 5) begin
        pend = pend | raise_mid;
        req  = pend;
      end
      det_y = (c >= 3 && c <= W + 2) ? bit_of(yp, c - 3) : 1'($urandom);
      chk("run_gnt", 32'(gnt), 0);
      chk("run_busy", 32'(busy), 1);
      if (c <= W + 1) begin
        chk("det_x", 32'(det_x), 32'(bit_of(w, W - 1 - (c - 2))));
        chk("shift_rstn", 32'(det_rst_n), 1);
      end else if (c == W + 2) begin
        chk("drain_x", 32'(det_x), 0);
      end
      if (c < W + 3) begin
        chk("run_done", 32'(done), 0);
        chk_hold("run");
      end else begin
        chk("done", 32'(done), 1);
        chk("done_id", 32'(done_id), exp_id);
        chk("hit_count", 32'(hit_count), $countones(yp));
        chk("last_y", 32'(last_y), 32'(bit_of(yp, W - 1)));
        prev_id   = exp_id;
        prev_hit  = $countones(yp);
        prev_last = int'(bit_of(yp, W - 1));
      end
    end
    @(negedge clock);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_rstn", 32'(det_rst_n), 1);
    chk("idle_x", 32'(det_x), 0);
    chk_hold("idle");
  endtask

  // Grants id (req left high), then asserts reset during the given cycle after the grant.
  task automatic abort_xfer(input int id, input int cyc_n);
    int           wait_n;
    logic [N-1:0] oh;
    oh   = N'(1) << id;
    pend = pend | oh;
    req  = pend;
    wait_n = 0;
    while (gnt === '0 && wait_n < 40) begin
      @(negedge clock);
      wait_n++;
    end
    chk("abort_gnt", 32'(gnt), 32'(oh));
    for (int c = 2; c <= cyc_n; c++) begin
      @(negedge clock);
      det_y = 1'b1;
      chk("abort_busy", 32'(busy), 1);
    end
    reset = 1'b0;
    #1;
    chk("rst_rstn", 32'(det_rst_n), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(det_x), 0);
    chk("rst_hit", 32'(hit_count), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_id", 32'(done_id), 0);
    chk("rst_last", 32'(last_y), 0);
    mptr      = 0;
    prev_id   = 0;
    prev_hit  = 0;
    prev_last = 0;
    @(negedge clock);
    chk("rst_hold_rstn", 32'(det_rst_n), 0);
    chk("rst_hold_done", 32'(done), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_word(i, '0, '0);
    #2 reset = 1'b0;
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_rstn", 32'(det_rst_n), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_x", 32'(det_x), 0);
    chk("reset_hit", 32'(hit_count), 0);
    chk("reset_last", 32'(last_y), 0);
    chk("reset_id", 32'(done_id), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("release_rstn", 32'(det_rst_n), 1);
    chk("release_busy", 32'(busy), 0);

    // Round-robin under continuous request, then 0 and 2 raised together
    for (int i = 0; i < N; i++) set_word(i, 8'($urandom), 8'($urandom));
    pend = 4'b1111;
    req  = pend;
    serve(0, '0);
    for (int i = 1; i < N; i++) serve(W + 4, '0);
    pend = pend | 4'b0101;
    req  = pend;
    serve(W + 4, '0);
    serve(W + 4, '0);

    // Single request, det_y held low
    set_word(0, 8'hB6, 8'h00);
    pend = 4'b0001;
    req  = pend;
    serve(0, '0);

    // All hits on requester 2
    set_word(2, 8'($urandom), 8'hFF);
    pend = 4'b0100;
    req  = pend;
    serve(0, '0);

    // Hits on bits 2,5,7 then 2,5
    set_word(1, 8'($urandom), 8'hA4);
    pend = 4'b0010;
    req  = pend;
    serve(0, '0);
    set_word(1, 8'($urandom), 8'h24);
    pend = 4'b0010;
    req  = pend;
    serve(0, '0);

    // Late request raised during shift of requester 0
    set_word(0, 8'($urandom), 8'($urandom));
    set_word(1, 8'($urandom), 8'hFF);
    pend = 4'b0001;
    req  = pend;
    serve(0, 4'b0010);
    serve(W + 4, '0);

    // Reset in shift cycle 5 with req[3] held, then a fresh grant of 3
    set_word(3, 8'($urandom), 8'($urandom));
    pend = '0;
    abort_xfer(3, 6);
    reset = 1'b1;
    serve(0, '0);

    // Abort requester 2 so ptr would be 3; after reset ptr=0 picks 1 before 3
    set_word(1, 8'($urandom), 8'($urandom));
    set_word(2, 8'($urandom), 8'($urandom));
    pend = '0;
    abort_xfer(2, 4);
    pend = pend | 4'b1010;
    req  = pend;
    reset = 1'b1;
    serve(0, '0);
    serve(W + 4, '0);
    serve(W + 4, '0);

    // Random request masks, words and detector patterns
    for (int r = 0; r < 6; r++) begin
      logic [N-1:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if (((mask >> i) & 1) != 0) set_word(i, 8'($urandom), 8'($urandom));
      end
      pend = pend | mask;
      req  = pend;
      for (int g = 0; g < N && pend != '0; g++) serve(0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
